// File: rtl/gpio_controller.sv
// ---------------------------------------------------------------------------
// gpio_controller
//
// Memory-mapped GPIO block for the I/O window of the memory controller.
// Provides IO_WIDTH pins with per-pin direction, atomic set/clear/toggle of
// the output register, synchronised pin inputs, and per-pin rising/falling
// edge detection with sticky status and a level interrupt.
//
// All state updates on the falling edge of clock (memory-system convention).
//
// Ports:
//   clock        in   1         system clock, falling-edge active
//   reset_n      in   1         asynchronous active-low reset
//   data_out     out  32        registered read data
//   io_out       out  IO_WIDTH  pin output values (DATA_OUT register)
//   io_oe        out  IO_WIDTH  per-pin output enable (DIR register), 1 = drive
//   irq          out  1         level interrupt, OR of IRQ_STATUS bits
//   data_in      in   32        write data
//   address      in   5         word offset within the I/O window
//   io_in        in   IO_WIDTH  asynchronous pin inputs
//   chip_select  in   1         window selected
//   we           in   1         write enable, qualified by chip_select
//
// Register map (word offset):
//   0x00 DATA_OUT RW, 0x01 DIR RW, 0x02 DATA_IN RO, 0x03 SET WO,
//   0x04 CLEAR WO, 0x05 TOGGLE WO, 0x06 IRQ_EN_RISE RW, 0x07 IRQ_EN_FALL RW,
//   0x08 IRQ_STATUS R/W1C, all other offsets read 0 and ignore writes.
// ---------------------------------------------------------------------------
module gpio_controller #(
    parameter int IO_WIDTH    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clock,
    input  logic                reset_n,
    output logic [31:0]         data_out,
    output logic [IO_WIDTH-1:0] io_out,
    output logic [IO_WIDTH-1:0] io_oe,
    output logic                irq,
    input  logic [31:0]         data_in,
    input  logic [4:0]          address,
    input  logic [IO_WIDTH-1:0] io_in,
    input  logic                chip_select,
    input  logic                we
);

    localparam logic [4:0] ADDR_DATA_OUT = 5'h00;
    localparam logic [4:0] ADDR_DIR      = 5'h01;
    localparam logic [4:0] ADDR_DATA_IN  = 5'h02;
    localparam logic [4:0] ADDR_SET      = 5'h03;
    localparam logic [4:0] ADDR_CLEAR    = 5'h04;
    localparam logic [4:0] ADDR_TOGGLE   = 5'h05;
    localparam logic [4:0] ADDR_EN_RISE  = 5'h06;
    localparam logic [4:0] ADDR_EN_FALL  = 5'h07;
    localparam logic [4:0] ADDR_STATUS   = 5'h08;

    // Zero-extend a pin-wide field onto the 32-bit bus. Written as a function
    // so that IO_WIDTH = 32 needs no zero-width replication.
    function automatic logic [31:0] zext(input logic [IO_WIDTH-1:0] val);
        logic [31:0] res;
        res               = 32'h0000_0000;
        res[IO_WIDTH-1:0] = val;
        return res;
    endfunction

    // Registered state
    logic [IO_WIDTH-1:0] r_data_out;
    logic [IO_WIDTH-1:0] r_dir;
    logic [IO_WIDTH-1:0] r_en_rise;
    logic [IO_WIDTH-1:0] r_en_fall;
    logic [IO_WIDTH-1:0] r_status;
    logic [IO_WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [IO_WIDTH-1:0] r_hist;
    logic [31:0]         r_rdata;

    // Combinational next-state and decode
    logic                w_wr;
    logic                w_rd;
    logic [IO_WIDTH-1:0] w_wdata;
    logic [IO_WIDTH-1:0] w_sync;
    logic [IO_WIDTH-1:0] w_rise;
    logic [IO_WIDTH-1:0] w_fall;
    logic [IO_WIDTH-1:0] w_event;
    logic [IO_WIDTH-1:0] w_clr;
    logic [IO_WIDTH-1:0] w_data_out_nxt;
    logic [IO_WIDTH-1:0] w_dir_nxt;
    logic [IO_WIDTH-1:0] w_en_rise_nxt;
    logic [IO_WIDTH-1:0] w_en_fall_nxt;
    logic [IO_WIDTH-1:0] w_status_nxt;
    logic [31:0]         w_rdata_mux;

    assign w_wr    = chip_select & we;
    assign w_rd    = chip_select & ~we;
    assign w_wdata = data_in[IO_WIDTH-1:0];

    // Edge detection compares the last synchroniser stage to its history flop.
    assign w_sync  = r_sync[SYNC_STAGES-1];
    assign w_rise  = w_sync & ~r_hist;
    assign w_fall  = ~w_sync & r_hist;
    assign w_event = (w_rise & r_en_rise) | (w_fall & r_en_fall);

    // Write decode: computes the next value of every writable register.
    always_comb begin
        w_data_out_nxt = r_data_out;
        w_dir_nxt      = r_dir;
        w_en_rise_nxt  = r_en_rise;
        w_en_fall_nxt  = r_en_fall;
        w_clr          = '0;
        if (w_wr) begin
            case (address)
                ADDR_DATA_OUT: w_data_out_nxt = w_wdata;
                ADDR_DIR:      w_dir_nxt      = w_wdata;
                ADDR_SET:      w_data_out_nxt = r_data_out | w_wdata;
                ADDR_CLEAR:    w_data_out_nxt = r_data_out & ~w_wdata;
                ADDR_TOGGLE:   w_data_out_nxt = r_data_out ^ w_wdata;
                ADDR_EN_RISE:  w_en_rise_nxt  = w_wdata;
                ADDR_EN_FALL:  w_en_fall_nxt  = w_wdata;
                ADDR_STATUS:   w_clr          = w_wdata;
                default:       w_clr          = '0;
            endcase
        end else begin
            w_clr = '0;
        end
    end

    // Sticky status: clear is applied first so a same-edge event keeps the bit set.
    assign w_status_nxt = (r_status & ~w_clr) | w_event;

    // Read mux: selects the addressed register, zero-extended to the bus width.
    always_comb begin
        w_rdata_mux = 32'h0000_0000;
        case (address)
            ADDR_DATA_OUT: w_rdata_mux = zext(r_data_out);
            ADDR_DIR:      w_rdata_mux = zext(r_dir);
            ADDR_DATA_IN:  w_rdata_mux = zext(w_sync);
            ADDR_EN_RISE:  w_rdata_mux = zext(r_en_rise);
            ADDR_EN_FALL:  w_rdata_mux = zext(r_en_fall);
            ADDR_STATUS:   w_rdata_mux = zext(r_status);
            default:       w_rdata_mux = 32'h0000_0000;
        endcase
    end

    // Control and status registers.
    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_data_out <= '0;
            r_dir      <= '0;
            r_en_rise  <= '0;
            r_en_fall  <= '0;
            r_status   <= '0;
        end else begin
            r_data_out <= w_data_out_nxt;
            r_dir      <= w_dir_nxt;
            r_en_rise  <= w_en_rise_nxt;
            r_en_fall  <= w_en_fall_nxt;
            r_status   <= w_status_nxt;
        end
    end

    // Input synchroniser chain plus history flop for edge detection.
    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_hist <= '0;
        end else begin
            r_sync[0] <= io_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_hist <= w_sync;
        end
    end

    // Read data register: loads on reads, holds during writes, zero when idle.
    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= 32'h0000_0000;
        end else if (w_rd) begin
            r_rdata <= w_rdata_mux;
        end else if (w_wr) begin
            r_rdata <= r_rdata;
        end else begin
            r_rdata <= 32'h0000_0000;
        end
    end

    assign data_out = r_rdata;
    assign io_out   = r_data_out;
    assign io_oe    = r_dir;
    assign irq      = |r_status;

endmodule

// File: tb/tb_gpio_controller.sv
// ---------------------------------------------------------------------------
// tb_gpio_controller
//
// Directed testbench for gpio_controller. Three instances share the bus:
// index 0 is the default 4-pin block, index 1 has 32 pins, index 2 has 1 pin.
// chip_select is driven per instance.
// ---------------------------------------------------------------------------
module tb_gpio_controller;

    logic        clock;
    logic        reset_n;
    logic [4:0]  address;
    logic [31:0] data_in;
    logic        we;
    logic [2:0]  cs;

    logic [3:0]  io_in0;
    logic [31:0] data_out0;
    logic [3:0]  io_out0;
    logic [3:0]  io_oe0;
    logic        irq0;

    logic [31:0] io_in32;
    logic [31:0] data_out32;
    logic [31:0] io_out32;
    logic [31:0] io_oe32;
    logic        irq32;

    logic [0:0]  io_in1;
    logic [31:0] data_out1;
    logic [0:0]  io_out1;
    logic [0:0]  io_oe1;
    logic        irq1;

    int checks;
    int failures;

    gpio_controller #(.IO_WIDTH(4), .SYNC_STAGES(2)) u_dut (
        .clock(clock), .reset_n(reset_n), .data_out(data_out0),
        .io_out(io_out0), .io_oe(io_oe0), .irq(irq0), .data_in(data_in),
        .address(address), .io_in(io_in0), .chip_select(cs[0]), .we(we)
    );

    gpio_controller #(.IO_WIDTH(32), .SYNC_STAGES(2)) u_dut32 (
        .clock(clock), .reset_n(reset_n), .data_out(data_out32),
        .io_out(io_out32), .io_oe(io_oe32), .irq(irq32), .data_in(data_in),
        .address(address), .io_in(io_in32), .chip_select(cs[1]), .we(we)
    );

    gpio_controller #(.IO_WIDTH(1), .SYNC_STAGES(2)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .data_out(data_out1),
        .io_out(io_out1), .io_oe(io_oe1), .irq(irq1), .data_in(data_in),
        .address(address), .io_in(io_in1), .chip_select(cs[2]), .we(we)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Bus write: drive on the rising edge, committed on the following falling edge.
    task automatic do_write(input int which, input logic [4:0] a, input logic [31:0] d);
        @(posedge clock);
        address = a;
        data_in = d;
        we      = 1'b1;
        cs      = 3'b001 << which;
        @(negedge clock);
        #1;
        cs = 3'b000;
        we = 1'b0;
    endtask

    task automatic do_read(input int which, input logic [4:0] a, output logic [31:0] q);
        @(posedge clock);
        address = a;
        we      = 1'b0;
        cs      = 3'b001 << which;
        @(negedge clock);
        #1;
        case (which)
            0:       q = data_out0;
            1:       q = data_out32;
            default: q = data_out1;
        endcase
        cs = 3'b000;
    endtask

    task automatic wait_edges(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
        end
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] q;
        reset_n = 1'b0;
        io_in0  = 4'hF;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            address = 5'($urandom_range(0, 31));
            data_in = $urandom;
            we      = 1'($urandom_range(0, 1));
            cs      = 3'($urandom_range(0, 7));
            @(negedge clock);
            #1;
            checks++;
            if ({data_out0, io_out0, io_oe0, irq0} !== 41'd0) begin
                failures++;
                $display("FAIL reset_hold: data_out=%h io_out=%h io_oe=%h irq=%b, expected all 0",
                         data_out0, io_out0, io_oe0, irq0);
            end
        end
        cs = 3'b000;
        we = 1'b0;
        checks++;
        if (data_out32 !== 32'h0 || io_out32 !== 32'h0) begin
            failures++;
            $display("FAIL reset_hold32: data_out=%h io_out=%h, expected 0", data_out32, io_out32);
        end
        reset_n = 1'b1;
        wait_edges(2);
        do_read(0, 5'h02, q);
        checks++;
        if (q !== 32'h0000_000F) begin
            failures++;
            $display("FAIL reset_data_in: got %h, expected 0000000f", q);
        end
    endtask

    task automatic test_rw_atomics();
        logic [31:0] q;
        io_in0 = 4'h0;
        do_write(0, 5'h00, 32'h0000_0005);
        checks++;
        if (io_out0 !== 4'h5) begin failures++; $display("FAIL data_out_wr: io_out=%h expected 5", io_out0); end
        do_write(0, 5'h01, 32'h0000_000F);
        checks++;
        if (io_oe0 !== 4'hF) begin failures++; $display("FAIL dir_wr: io_oe=%h expected f", io_oe0); end
        do_write(0, 5'h03, 32'h0000_0002);
        checks++;
        if (io_out0 !== 4'h7) begin failures++; $display("FAIL set: io_out=%h expected 7", io_out0); end
        do_write(0, 5'h04, 32'h0000_0004);
        checks++;
        if (io_out0 !== 4'h3) begin failures++; $display("FAIL clear: io_out=%h expected 3", io_out0); end
        do_write(0, 5'h05, 32'h0000_0009);
        checks++;
        if (io_out0 !== 4'hA) begin failures++; $display("FAIL toggle: io_out=%h expected a", io_out0); end
        do_read(0, 5'h00, q);
        checks++;
        if (q !== 32'h0000_000A) begin failures++; $display("FAIL read_data_out: got %h expected 0000000a", q); end
        do_read(0, 5'h03, q);
        checks++;
        if (q !== 32'h0) begin failures++; $display("FAIL read_set: got %h expected 0", q); end
        do_read(0, 5'h01, q);
        checks++;
        if (q !== 32'h0000_000F) begin failures++; $display("FAIL read_dir: got %h expected 0000000f", q); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] q;
        do_read(0, 5'h00, q);
        do_write(0, 5'h06, 32'h0000_0000);
        checks++;
        if (data_out0 !== 32'h0000_000A) begin
            failures++;
            $display("FAIL hold_during_write: data_out=%h expected 0000000a", data_out0);
        end
        wait_edges(1);
        checks++;
        if (data_out0 !== 32'h0) begin
            failures++;
            $display("FAIL idle_zero: data_out=%h expected 0", data_out0);
        end
    endtask

    task automatic test_sync_latency();
        logic [31:0] q;
        io_in0 = 4'h0;
        wait_edges(4);
        io_in0 = 4'h3;
        do_read(0, 5'h02, q);
        checks++;
        if (q !== 32'h0) begin failures++; $display("FAIL sync_edge1: got %h expected 0", q); end
        do_read(0, 5'h02, q);
        checks++;
        if (q !== 32'h0) begin failures++; $display("FAIL sync_edge2: got %h expected 0", q); end
        do_read(0, 5'h02, q);
        checks++;
        if (q !== 32'h0000_0003) begin failures++; $display("FAIL sync_edge3: got %h expected 00000003", q); end
    endtask

    task automatic test_edge_irq();
        logic [31:0] q;
        io_in0 = 4'b0010;
        wait_edges(4);
        do_write(0, 5'h06, 32'h0000_0001);
        do_write(0, 5'h07, 32'h0000_0002);
        do_read(0, 5'h08, q);
        checks++;
        if (q !== 32'h0 || irq0 !== 1'b0) begin
            failures++;
            $display("FAIL irq_idle: status=%h irq=%b expected 0/0", q, irq0);
        end
        io_in0 = 4'b0011;
        wait_edges(4);
        io_in0 = 4'b0001;
        wait_edges(4);
        do_read(0, 5'h08, q);
        checks++;
        if (q !== 32'h0000_0003 || irq0 !== 1'b1) begin
            failures++;
            $display("FAIL irq_both: status=%h irq=%b expected 3/1", q, irq0);
        end
        do_write(0, 5'h06, 32'h0000_0000);
        do_read(0, 5'h08, q);
        checks++;
        if (q !== 32'h0000_0003) begin
            failures++;
            $display("FAIL enable_gating: status=%h expected 3", q);
        end
        do_write(0, 5'h08, 32'h0000_0001);
        do_read(0, 5'h08, q);
        checks++;
        if (q !== 32'h0000_0002 || irq0 !== 1'b1) begin
            failures++;
            $display("FAIL w1c_bit0: status=%h irq=%b expected 2/1", q, irq0);
        end
        do_write(0, 5'h08, 32'h0000_0002);
        checks++;
        if (irq0 !== 1'b0) begin failures++; $display("FAIL w1c_bit1: irq=%b expected 0", irq0); end
    endtask

    task automatic test_collision();
        logic [31:0] q;
        do_write(0, 5'h06, 32'h0000_0001);
        io_in0 = 4'b0000;
        wait_edges(4);
        do_read(0, 5'h08, q);
        checks++;
        if (q !== 32'h0) begin failures++; $display("FAIL collision_pre: status=%h expected 0", q); end
        io_in0 = 4'b0001;
        wait_edges(2);
        // rise on bit0 is now pending; the W1C lands on the same edge
        do_write(0, 5'h08, 32'h0000_0001);
        checks++;
        if (irq0 !== 1'b1) begin failures++; $display("FAIL collision_irq: irq=%b expected 1", irq0); end
        do_read(0, 5'h08, q);
        checks++;
        if (q !== 32'h0000_0001) begin failures++; $display("FAIL collision_status: status=%h expected 1", q); end
        do_write(0, 5'h08, 32'h0000_0001);
        checks++;
        if (irq0 !== 1'b0) begin failures++; $display("FAIL collision_clear: irq=%b expected 0", irq0); end
    endtask

    task automatic test_unmapped();
        logic [31:0] q;
        do_write(0, 5'h0C, 32'hFFFF_FFFF);
        @(posedge clock);
        address = 5'h00;
        data_in = 32'hFFFF_FFFF;
        we      = 1'b1;
        cs      = 3'b000;
        @(negedge clock);
        #1;
        we = 1'b0;
        checks++;
        if (io_out0 !== 4'hA || io_oe0 !== 4'hF || data_out0 !== 32'h0) begin
            failures++;
            $display("FAIL unselected_write: io_out=%h io_oe=%h data_out=%h expected a/f/0",
                     io_out0, io_oe0, data_out0);
        end
        do_read(0, 5'h0C, q);
        checks++;
        if (q !== 32'h0) begin failures++; $display("FAIL read_unmapped: got %h expected 0", q); end
        do_read(0, 5'h08, q);
        checks++;
        if (q !== 32'h0) begin failures++; $display("FAIL unmapped_status: got %h expected 0", q); end
    endtask

    task automatic test_width();
        logic [31:0] q;
        do_write(1, 5'h00, 32'hDEAD_BEEF);
        do_read(1, 5'h00, q);
        checks++;
        if (q !== 32'hDEAD_BEEF || io_out32 !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL width32: read=%h io_out=%h expected deadbeef", q, io_out32);
        end
        do_write(2, 5'h00, 32'hFFFF_FFFF);
        do_read(2, 5'h00, q);
        checks++;
        if (q !== 32'h0000_0001 || io_out1 !== 1'b1) begin
            failures++;
            $display("FAIL width1: read=%h io_out=%b expected 00000001/1", q, io_out1);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        address  = 5'h00;
        data_in  = 32'h0;
        we       = 1'b0;
        cs       = 3'b000;
        io_in0   = 4'h0;
        io_in32  = 32'h0;
        io_in1   = 1'b0;
        @(negedge clock);
        #1;
        test_reset();
        test_rw_atomics();
        test_back_to_back();
        test_sync_latency();
        test_edge_irq();
        test_collision();
        test_unmapped();
        test_width();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpio_controller.md
Name: gpio_controller

Overview:
- Parametrised successor to the fixed 4-bit memory-mapped I/O block.
- Occupies the I/O window (0x0020-0x003F) of the memory controller, which decodes the window and drives chip_select.
- Provides IO_WIDTH pins with per-pin direction, atomic set/clear/toggle of outputs, and synchronised inputs.
- Adds per-pin rising/falling edge detection with sticky status and a level interrupt to the CPU.

Parameters:
- IO_WIDTH, 4, number of GPIO pins (1..32); register fields are bits [IO_WIDTH-1:0], upper bits read 0 and ignore writes.
- SYNC_STAGES, 2, flops in the io_in synchroniser chain (>=2).

Ports:
- clock  input  1  system clock; all state updates on the falling edge (memory-system convention).
- reset_n  input  1  asynchronous active-low reset.
- data_out  output  32  read data, registered.
- io_out  output  IO_WIDTH  pin output values (DATA_OUT register).
- io_oe  output  IO_WIDTH  per-pin output enable (DIR register); 1 = drive.
- irq  output  1  level interrupt = OR of IRQ_STATUS bits.
- data_in  input  32  write data.
- address  input  5  word offset within the I/O window (address[4:0]).
- io_in  input  IO_WIDTH  asynchronous pin inputs.
- chip_select  input  1  window selected.
- we  input  1  write enable; valid only with chip_select.

Behaviour:
- Reset (reset_n low, asynchronous): all registers, synchroniser flops, edge history, data_out and irq go to 0. Leaving reset does not create edges: history and sync chain are all 0, so pins already high produce one rising event SYNC_STAGES+1 edges later if IRQ_EN_RISE is set.
- Register map (word offset):
  - 0x00 DATA_OUT, RW.
  - 0x01 DIR, RW.
  - 0x02 DATA_IN, RO: last synchroniser stage.
  - 0x03 SET, WO: DATA_OUT |= wdata.
  - 0x04 CLEAR, WO: DATA_OUT &= ~wdata.
  - 0x05 TOGGLE, WO: DATA_OUT ^= wdata.
  - 0x06 IRQ_EN_RISE, RW.
  - 0x07 IRQ_EN_FALL, RW.
  - 0x08 IRQ_STATUS, R / write-1-to-clear.
  - 0x09-0x1F: read 0, writes ignored.
  - SET/CLEAR/TOGGLE read 0.
- Write: on a falling edge with chip_select=1, we=1, the addressed register updates. data_out is unchanged during writes.
- Read: on a falling edge with chip_select=1, we=0, data_out <= register value zero-extended to 32 bits. Valid from that edge until the next falling edge.
- Not selected: data_out <= 0 on each falling edge; no register changes.
- Synchroniser: io_in passes through SYNC_STAGES flops, then one history flop.
  - rise = sync & ~hist; fall = ~sync & hist.
  - Every falling edge: IRQ_STATUS |= (rise & IRQ_EN_RISE) | (fall & IRQ_EN_FALL).
- Simultaneous W1C and new event on the same bit: the set wins, and the bit remains 1.
- Enables gate only the setting of status bits. Disabling an enable leaves existing status bits set.
- irq = |IRQ_STATUS from registered state, with no added latency.
- DATA_IN reflects the pins regardless of DIR. No internal loopback.
- Reset asserted mid-operation overrides any in-progress write or read.

Test Plan:
- Reset: hold reset_n=0 with io_in=4'hF and random bus activity -> data_out=0, io_out=0, io_oe=0, irq=0. After release, reading 0x02 after 3 falling edges -> 0x0000000F.
- RW and atomics: write DATA_OUT=0x5, DIR=0xF, then SET 0x2, CLEAR 0x4, TOGGLE 0x9 -> io_out sequence 0x5, 0x7, 0x3, 0xA. Reading 0x00 -> 0x0000000A. Reading 0x03 -> 0.
- Synchroniser latency: io_in 0->0x3 just after a falling edge -> DATA_IN reads 0x3 only from the 2nd falling edge onward (SYNC_STAGES=2).
- Edge interrupts: IRQ_EN_RISE=0x1, IRQ_EN_FALL=0x2. Pulse io_in[0] 0->1, then io_in[1] 1->0 -> IRQ_STATUS=0x3, irq=1. Write 0x08 with 0x1 -> status 0x2, irq stays 1. Write 0x2 -> irq=0.
- Collision: W1C of bit0 issued on the same edge a new rising event on bit0 is detected -> IRQ_STATUS[0]=1, irq=1.
- Unmapped/unselected: write 0xFFFFFFFF to 0x0C and to 0x00 with chip_select=0 -> no register changes. Read of 0x0C -> 0. data_out=0 whenever unselected.
- Width: IO_WIDTH=32, write DATA_OUT=0xDEADBEEF -> read back 0xDEADBEEF. IO_WIDTH=1, write 0xFFFFFFFF -> read back 0x00000001.
